sram_mem_controller: RTL and testbench

- Multi-cycle memory-stage controller between the pipeline's MEM stage and an external 16-bit asynchronous SRAM.
- Converts one 32-bit LD/ST request (mem_read/mem_write from the opcode decoder, plus the ALU address) into two sequenced halfword SRAM accesses.
- Drives ready low while busy. The top level uses ~ready as the pipeline freeze.

---
 rtl/sram_mem_controller.sv | 116 +++++++++++
 tb/tb_sram_mem_controller.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/sram_mem_controller.sv
// Memory-stage controller: splits one 32-bit load/store into two sequenced
// halfword accesses on a 16-bit asynchronous SRAM, holding ready low while busy.
//
// state | meaning
// IDLE  | waiting for mem_read/mem_write; request latched on accept
// LOW   | halfword 0 access ({word,0}), HALF_CYCLES cycles
// HIGH  | halfword 1 access ({word,1}), HALF_CYCLES cycles
// DONE  | one-cycle completion, ready high
module sram_mem_controller #(
  parameter int HALF_CYCLES = 3,
  parameter int BASE_ADDR   = 1024,
  parameter int ADDR_W      = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [31:0]       address,
  input  logic [31:0]       write_data,
  output logic [31:0]       read_data,
  output logic              ready,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_dq_out,
  input  logic [15:0]       sram_dq_in,
  output logic              sram_dq_oe,
  output logic              sram_we_n,
  output logic              sram_oe_n
);

  localparam int CNT_W = $clog2(HALF_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  count, count_nxt;
  logic              op_wr;
  logic [ADDR_W-2:0] word;
  logic [31:0]       wdata;
  logic [31:0]       offset;
  logic              req;
  logic              last;
  logic              unused_bits;

  assign req         = mem_read | mem_write;
  assign last        = (count == LAST);
  assign offset      = address - 32'(BASE_ADDR);
  // Byte lane bits and the out-of-range upper word bits are dropped: wrap is intended.
  assign unused_bits = ^{offset[31:ADDR_W+1], offset[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      op_wr     <= 1'b0;
      word      <= '0;
      wdata     <= '0;
      read_data <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      if (state == IDLE && req) begin
        op_wr <= mem_write;
        word  <= offset[ADDR_W:2];
        wdata <= write_data;
      end
      if (!op_wr && last) begin
        if (state == LOW)  read_data[15:0]  <= sram_dq_in;
        if (state == HIGH) read_data[31:16] <= sram_dq_in;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    count_nxt   = count;
    ready       = 1'b0;
    sram_addr   = {word, 1'b0};
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    sram_oe_n   = 1'b1;
    case (state)
      IDLE: begin
        ready = !req;
        if (req) begin
          state_nxt = LOW;
          count_nxt = '0;
        end
      end
      LOW, HIGH: begin
        sram_addr = {word, state == HIGH};
        if (op_wr) begin
          sram_dq_oe  = 1'b1;
          sram_dq_out = (state == HIGH) ? wdata[31:16] : wdata[15:0];
          // we_n rises on the last cycle so address/data hold past the rising edge
          sram_we_n   = last;
        end else begin
          sram_oe_n = 1'b0;
        end
        if (last) begin
          count_nxt = '0;
          state_nxt = (state == LOW) ? HIGH : DONE;
        end else begin
          count_nxt = count + 1'b1;
        end
      end
      DONE: begin
        ready     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sram_mem_controller.sv
// Directed bench for sram_mem_controller with an SRAM model, a reference word
// store and a queue of expected load results.
module tb_sram_mem_controller;
  localparam int H = 3;

  logic        clk, rst;
  logic        mem_read, mem_write;
  logic [31:0] address, write_data, read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n, sram_oe_n;

  int tests = 0;
  int fails = 0;

  logic [15:0] sram [0:262143];
  logic [31:0] ref_word [int];
  logic [31:0] exp_q [$];
  logic [31:0] ref_rd;

  sram_mem_controller #(.HALF_CYCLES(H), .BASE_ADDR(1024), .ADDR_W(18)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .address(address), .write_data(write_data), .read_data(read_data),
    .ready(ready), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
    .sram_dq_in(sram_dq_in), .sram_dq_oe(sram_dq_oe),
    .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign sram_dq_in = sram[sram_addr];
  always @(posedge clk)
    if (!sram_we_n && sram_dq_oe) sram[sram_addr] <= sram_dq_out;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_we_n"}, 32'(sram_we_n), 32'd1);
    chk({tag, "_oe_n"}, 32'(sram_oe_n), 32'd1);
    chk({tag, "_dq_oe"}, 32'(sram_dq_oe), 32'd0);
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_ready", 32'(ready), 32'd1);
      check_idle_outputs("idle");
    end
  endtask

  // Starts a request one tick after a rising edge (cycle 0) and checks cycles 0..7.
  // Inputs are scrambled in cycle 1 to confirm the latched copy is used.
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data);
    logic [31:0] d;
    logic [16:0] w;
    logic        op;
    logic        phase;
    int          k;
    logic [31:0] e;
    d  = addr - 32'd1024;
    w  = d[18:2];
    op = wr;
    @(posedge clk); #1;
    mem_read = rd; mem_write = wr; address = addr; write_data = data;
    if (op) ref_word[int'(w)] = data;
    else exp_q.push_back(ref_word.exists(int'(w)) ? ref_word[int'(w)] : 32'd0);
    @(negedge clk);
    chk("ready_c0", 32'(ready), 32'd0);
    for (int c = 1; c <= 2*H+1; c++) begin
      @(negedge clk);
      if (c == 1) begin
        mem_read = 1'b0; mem_write = 1'b0;
        address = 32'hFFFF_FFFC; write_data = ~data;
      end
      if (c <= 2*H) begin
        phase = (c > H);
        k     = (c - 1) % H;
        chk("ready_busy", 32'(ready), 32'd0);
        chk("sram_addr", 32'(sram_addr), 32'({w, phase}));
        if (op) begin
          chk("wr_dq_oe", 32'(sram_dq_oe), 32'd1);
          chk("wr_oe_n", 32'(sram_oe_n), 32'd1);
          chk("wr_we_n", 32'(sram_we_n), (k == H-1) ? 32'd1 : 32'd0);
          chk("wr_dq_out", 32'(sram_dq_out), phase ? 32'(data[31:16]) : 32'(data[15:0]));
        end else begin
          chk("rd_dq_oe", 32'(sram_dq_oe), 32'd0);
          chk("rd_we_n", 32'(sram_we_n), 32'd1);
          chk("rd_oe_n", 32'(sram_oe_n), 32'd0);
        end
      end else begin
        chk("ready_done", 32'(ready), 32'd1);
        check_idle_outputs("done");
        if (op) begin
          chk("rd_unchanged", read_data, ref_rd);
          chk("sram_lo", 32'(sram[{w, 1'b0}]), 32'(data[15:0]));
          chk("sram_hi", 32'(sram[{w, 1'b1}]), 32'(data[31:16]));
        end else begin
          chk("sb_size", 32'(exp_q.size()), 32'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("read_data", read_data, e);
            ref_rd = e;
          end
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 262144; i++) sram[i] = 16'h0000;
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
    address = '0; write_data = '0; ref_rd = '0;
    repeat (2) @(negedge clk);
    chk("rst_read_data", read_data, 32'd0);
    chk("rst_sram_addr", 32'(sram_addr), 32'd0);
    chk("rst_dq_out", 32'(sram_dq_out), 32'd0);
    chk("rst_ready", 32'(ready), 32'd1);
    check_idle_outputs("rst");
    @(posedge clk); #1 rst = 1'b0;
    idle(4);

    access(1'b0, 1'b1, 32'd1024, 32'hDEAD_BEEF);
    idle(2);
    access(1'b1, 1'b0, 32'd1024, 32'h0);
    idle(1);
    access(1'b0, 1'b1, 32'd1035, 32'h1234_5678);
    idle(1);
    access(1'b1, 1'b1, 32'd1040, 32'hCAFE_F00D);
    idle(1);
    access(1'b1, 1'b0, 32'd1035, 32'h0);
    access(1'b0, 1'b1, 32'd1044, 32'hA5A5_5A5A);
    access(1'b1, 1'b0, 32'd1044, 32'h0);
    access(1'b1, 1'b0, 32'd1040, 32'h0);
    idle(1);
    access(1'b0, 1'b1, 32'd0, 32'h0BAD_C0DE);
    access(1'b1, 1'b0, 32'd0, 32'h0);
    idle(1);

    @(posedge clk); #1;
    mem_write = 1'b1; address = 32'd1100; write_data = 32'h1111_2222;
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    mem_write = 1'b0;
    #1;
    chk("abort_read_data", read_data, 32'd0);
    chk("abort_sram_addr", 32'(sram_addr), 32'd0);
    chk("abort_dq_out", 32'(sram_dq_out), 32'd0);
    chk("abort_ready", 32'(ready), 32'd1);
    check_idle_outputs("abort");
    ref_rd = 32'd0;
    @(negedge clk) rst = 1'b0;
    idle(2);
    access(1'b0, 1'b1, 32'd1100, 32'h3333_4444);
    access(1'b1, 1'b0, 32'd1100, 32'h0);
    access(1'b1, 1'b0, 32'd1024, 32'h0);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
